// File: rtl/tdc_pkg.sv
// Shared types and default widths for the TDC shot controller.
package tdc_pkg;

  localparam int TDC_TOF_W   = 10;
  localparam int TDC_INT_W   = 5;
  localparam int TDC_RANGE_W = 15;
  localparam int TDC_SHOT_W  = 16;
  localparam int TDC_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_INT  = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_RECV      = 3'd4,
    ST_EMIT      = 3'd5,
    ST_GAP       = 3'd6
  } state_e;

  // Bit positions of the per-shot error cause vector.
  localparam int ERR_ONUM_ZERO     = 0;
  localparam int ERR_LAST_MISMATCH = 1;
  localparam int ERR_BEAT_OVF      = 2;
  localparam int ERR_TIMEOUT       = 3;
  localparam int ERR_N             = 4;

endpackage

// File: rtl/tdc_best_sel.sv
// Tracks the strongest beat of a shot and the saturating beat count.
module tdc_best_sel
  import tdc_pkg::*;
#(
  parameter int TOF_W = TDC_TOF_W,
  parameter int INT_W = TDC_INT_W
) (
  input  logic             clk5,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             hs_i,
  input  logic [TOF_W-1:0] tof_i,
  input  logic [INT_W-1:0] int_i,
  output logic [1:0]       beat_cnt_o,
  output logic [TOF_W-1:0] nxt_tof_o,
  output logic [INT_W-1:0] nxt_int_o,
  output logic [1:0]       nxt_cnt_o,
  output logic             err_cnt_overflow
);

  logic [TOF_W-1:0] tof_q;
  logic [INT_W-1:0] int_q;
  logic [1:0]       cnt_q;
  logic             accept;
  logic             take;

  // A fourth beat is dropped so the stored best stays from the first three.
  assign err_cnt_overflow = hs_i & (cnt_q == 2'd3);
  assign accept           = hs_i & ~err_cnt_overflow;
  assign take             = accept & ((cnt_q == 2'd0) | (int_i > int_q));

  assign nxt_cnt_o  = accept ? cnt_q + 2'd1 : cnt_q;
  assign nxt_tof_o  = take ? tof_i : tof_q;
  assign nxt_int_o  = take ? int_i : int_q;
  assign beat_cnt_o = cnt_q;

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      tof_q <= '0;
      int_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      tof_q <= '0;
      int_q <= '0;
      cnt_q <= '0;
    end else begin
      tof_q <= nxt_tof_o;
      int_q <= nxt_int_o;
      cnt_q <= nxt_cnt_o;
    end
  end

endmodule

// File: rtl/tdc_shot_ctrl.sv
// Shot sequencer: starts the TDC, collects its result stream and reduces
// each shot to a single strongest-return result.
//
// state     | meaning
// IDLE      | not running, waiting for cfg_run
// START     | tdc_start held high for START_HI cycles
// WAIT_INT  | waiting for end-of-window pulse from TDC
// WAIT_DATA | ready for first beat, no-return timeout running
// RECV      | receiving further beats, timeout restarts per beat
// EMIT      | result presented until res_ready
// GAP       | idle spacing before the next shot
module tdc_shot_ctrl
  import tdc_pkg::*;
#(
  parameter int TOF_W    = TDC_TOF_W,
  parameter int INT_W    = TDC_INT_W,
  parameter int RANGE_W  = TDC_RANGE_W,
  parameter int START_HI = 4,
  parameter int TIMEOUT  = 64,
  parameter int SHOT_W   = TDC_SHOT_W
) (
  input  logic               clk5,
  input  logic               rst_n,
  input  logic               cfg_run,
  input  logic [SHOT_W-1:0]  cfg_num_shots,
  input  logic [RANGE_W-1:0] cfg_range,
  input  logic [7:0]         cfg_gap,
  output logic               tdc_start,
  output logic [RANGE_W-1:0] tdc_range,
  input  logic               tdc_int,
  input  logic [TOF_W-1:0]   tdc_odata,
  input  logic [INT_W-1:0]   tdc_oint,
  input  logic [1:0]         tdc_onum,
  input  logic               tdc_olast,
  input  logic               tdc_ovalid,
  output logic               tdc_oready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [TOF_W-1:0]   res_tof,
  output logic [INT_W-1:0]   res_int,
  output logic [1:0]         res_hits,
  output logic               res_err,
  output logic               busy,
  output logic [SHOT_W-1:0]  shot_cnt
);

  localparam logic [TDC_CNT_W-1:0] START_CNT = TDC_CNT_W'(START_HI - 1);
  localparam logic [TDC_CNT_W-1:0] TMO_CNT   = TDC_CNT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [TDC_CNT_W-1:0]   cnt_q, cnt_d;
  logic [RANGE_W-1:0]     range_q, range_d;
  logic [SHOT_W-1:0]      shot_q, shot_d;
  logic [1:0]             onum_q;
  logic                   err_q, err_d;
  logic                   res_valid_q, res_valid_d;
  logic [TOF_W-1:0]       res_tof_q, res_tof_d;
  logic [INT_W-1:0]       res_int_q, res_int_d;
  logic [1:0]             res_hits_q, res_hits_d;
  logic                   res_err_q, res_err_d;

  logic                   hs;
  logic                   clear_best;
  logic                   load_start;
  logic                   load_res;
  logic                   tmo;
  logic [SHOT_W-1:0]      shot_inc;
  logic                   last_shot;

  logic [1:0]             beat_cnt;
  logic [TOF_W-1:0]       nxt_tof;
  logic [INT_W-1:0]       nxt_int;
  logic [1:0]             nxt_cnt;
  logic                   cnt_ovf;
  logic                   first_beat;
  logic [1:0]             onum_eff;
  logic [2:0]             beat_idx;
  logic [ERR_N-1:0]       err_cause;

  assign tdc_oready = (state_q == ST_WAIT_DATA) || (state_q == ST_RECV);
  assign tdc_start  = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);
  assign tdc_range  = range_q;
  assign shot_cnt   = shot_q;
  assign res_valid  = res_valid_q;
  assign res_tof    = res_tof_q;
  assign res_int    = res_int_q;
  assign res_hits   = res_hits_q;
  assign res_err    = res_err_q;

  assign hs        = tdc_ovalid & tdc_oready;
  assign tmo       = (cnt_q == '0) & ~hs;
  assign shot_inc  = shot_q + 1'b1;
  assign last_shot = (cfg_num_shots != '0) && (shot_inc == cfg_num_shots);

  tdc_best_sel #(
    .TOF_W (TOF_W),
    .INT_W (INT_W)
  ) u_best_sel (
    .clk5             (clk5),
    .rst_n            (rst_n),
    .clear_i          (clear_best),
    .hs_i             (hs),
    .tof_i            (tdc_odata),
    .int_i            (tdc_oint),
    .beat_cnt_o       (beat_cnt),
    .nxt_tof_o        (nxt_tof),
    .nxt_int_o        (nxt_int),
    .nxt_cnt_o        (nxt_cnt),
    .err_cnt_overflow (cnt_ovf)
  );

  // onum is only trusted from the first beat; later beats are checked against it.
  assign first_beat = (beat_cnt == 2'd0);
  assign onum_eff   = first_beat ? tdc_onum : onum_q;
  assign beat_idx   = {1'b0, beat_cnt} + 3'd1;

  always_comb begin
    err_cause                    = '0;
    err_cause[ERR_ONUM_ZERO]     = hs & (onum_eff == 2'd0);
    err_cause[ERR_LAST_MISMATCH] = hs & tdc_olast & (beat_idx != {1'b0, onum_eff});
    err_cause[ERR_BEAT_OVF]      = cnt_ovf;
    err_cause[ERR_TIMEOUT]       = (state_q == ST_RECV) & tmo;
    err_d                        = err_q | (|err_cause);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    range_d     = range_q;
    shot_d      = shot_q;
    res_valid_d = res_valid_q;
    res_tof_d   = res_tof_q;
    res_int_d   = res_int_q;
    res_hits_d  = res_hits_q;
    res_err_d   = res_err_q;
    clear_best  = 1'b0;
    load_start  = 1'b0;
    load_res    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_run) begin
          state_d    = ST_START;
          shot_d     = '0;
          clear_best = 1'b1;
          load_start = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == '0) state_d = ST_WAIT_INT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WAIT_INT: begin
        if (tdc_int) begin
          state_d = ST_WAIT_DATA;
          cnt_d   = TMO_CNT;
        end
      end
      ST_WAIT_DATA, ST_RECV: begin
        if (hs) begin
          cnt_d = TMO_CNT;
          if (tdc_olast) begin
            state_d  = ST_EMIT;
            load_res = 1'b1;
          end else begin
            state_d = ST_RECV;
          end
        end else if (tmo) begin
          state_d  = ST_EMIT;
          load_res = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          shot_d      = shot_inc;
          clear_best  = 1'b1;
          if (!cfg_run || last_shot) begin
            state_d = ST_IDLE;
          end else if (cfg_gap == 8'd0) begin
            state_d    = ST_START;
            load_start = 1'b1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = TDC_CNT_W'(cfg_gap - 8'd1);
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d    = ST_START;
          load_start = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_start) begin
      range_d = cfg_range;
      cnt_d   = START_CNT;
    end
    // Result reflects the beat accepted on the same edge that enters EMIT.
    if (load_res) begin
      res_valid_d = 1'b1;
      res_tof_d   = nxt_tof;
      res_int_d   = nxt_int;
      res_hits_d  = nxt_cnt;
      res_err_d   = err_d;
    end
  end

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      range_q     <= '0;
      shot_q      <= '0;
      res_valid_q <= 1'b0;
      res_tof_q   <= '0;
      res_int_q   <= '0;
      res_hits_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      range_q     <= range_d;
      shot_q      <= shot_d;
      res_valid_q <= res_valid_d;
      res_tof_q   <= res_tof_d;
      res_int_q   <= res_int_d;
      res_hits_q  <= res_hits_d;
      res_err_q   <= res_err_d;
    end
  end

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      onum_q <= '0;
      err_q  <= 1'b0;
    end else if (clear_best) begin
      onum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (hs && first_beat) onum_q <= tdc_onum;
      err_q <= err_d;
    end
  end

endmodule
